// File: rtl/bsg_demuxi2_gatestack_collect.sv
// Un-inverts inverted 2:1 mux-stack words and steers each bit to the i0 or i1 register by its select; optional BSG_DEMUXI2_COLLECT_FLOWTHRU_EN.
// Latency: accepting the word that completes both masks raises v_o on the next rising edge.
// Backpressure: ready_o=0 while the pair waits for yumi_i; with the flowthru macro, a word can be taken in the yumi_i cycle.
module bsg_demuxi2_gatestack_collect #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic [width_p-1:0] sel_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] o0_o,
    output logic [width_p-1:0] o1_o,
    input  logic               yumi_i
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e             state_r;
    logic [width_p-1:0] m0_r, m1_r;
    logic [width_p-1:0] o0_r, o1_r;
    logic [width_p-1:0] m0_n, m1_n;
    logic               accept;
    logic               done;

    always_comb begin
`ifdef BSG_DEMUXI2_COLLECT_FLOWTHRU_EN
        ready_o = reset_n_i & ((state_r == FILL) | yumi_i);
`else
        ready_o = reset_n_i & (state_r == FILL);
`endif
        accept = v_i & ready_o;
        m0_n   = m0_r | ~sel_i;
        m1_n   = m1_r | sel_i;
        done   = (&m0_n) & (&m1_n);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= FILL;
            m0_r    <= '0;
            m1_r    <= '0;
            o0_r    <= '0;
            o1_r    <= '0;
        end else begin
            // Data registers only change on accept; they are not cleared on yumi_i.
            if (accept) begin
                o1_r <= (o1_r & ~sel_i) | (~data_i & sel_i);
                o0_r <= (o0_r & sel_i) | (~data_i & ~sel_i);
            end
            case (state_r)
                FILL: begin
                    if (accept) begin
                        m0_r <= m0_n;
                        m1_r <= m1_n;
                        if (done) state_r <= FULL;
                    end
                end
                FULL: begin
                    if (yumi_i) begin
                        state_r <= FILL;
                        // A word taken in the yumi cycle starts a fresh collection.
                        m0_r    <= accept ? ~sel_i : '0;
                        m1_r    <= accept ? sel_i : '0;
                    end
                end
                default: state_r <= FILL;
            endcase
        end
    end

    assign v_o  = (state_r == FULL);
    assign o0_o = o0_r;
    assign o1_o = o1_r;

`ifndef SYNTHESIS
    yumi_only_when_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o
    );
`endif

endmodule

// File: tb/tb_bsg_demuxi2_gatestack_collect.sv
// Bench for bsg_demuxi2_gatestack_collect: directed scenarios plus random traffic against a word-history model.
module tb_bsg_demuxi2_gatestack_collect;

    localparam int W = 32;
`ifdef BSG_DEMUXI2_COLLECT_FLOWTHRU_EN
    localparam bit FLOW = 1'b1;
`else
    localparam bit FLOW = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         v_i = 1'b0;
    logic [W-1:0] data_i = '0;
    logic [W-1:0] sel_i = '0;
    logic         yumi_i = 1'b0;
    logic         ready_o, v_o;
    logic [W-1:0] o0_o, o1_o;

    int checks = 0;
    int errors = 0;

    // Model: the words of the current collection, the persistent recovered words, and the FULL flag.
    logic [W-1:0] cd[$];
    logic [W-1:0] cs[$];
    logic [W-1:0] o0_m, o1_m;
    bit           full_m;

    bsg_demuxi2_gatestack_collect #(.width_p(W)) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .v_i      (v_i),
        .data_i   (data_i),
        .sel_i    (sel_i),
        .ready_o  (ready_o),
        .v_o      (v_o),
        .o0_o     (o0_o),
        .o1_o     (o1_o),
        .yumi_i   (yumi_i)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic bit complete();
        logic [W-1:0] c0, c1;
        c0 = '0;
        c1 = '0;
        foreach (cs[i]) begin
            c0 = c0 | ~cs[i];
            c1 = c1 | cs[i];
        end
        return (&c0) && (&c1);
    endfunction

    task automatic model_reset();
        full_m = 1'b0;
        o0_m   = '0;
        o1_m   = '0;
        cd.delete();
        cs.delete();
    endtask

    task automatic model_apply(input logic [W-1:0] d, input logic [W-1:0] s);
        for (int b = 0; b < W; b++) begin
            if (s[b]) o1_m[b] = ~d[b];
            else      o0_m[b] = ~d[b];
        end
        cd.push_back(d);
        cs.push_back(s);
    endtask

    function automatic bit model_ready(input bit y);
        return !full_m || (FLOW && y);
    endfunction

    // Advance the model across the coming rising edge using the currently driven inputs.
    task automatic model_step();
        bit acc;
        acc = v_i && model_ready(yumi_i);
        if (full_m) begin
            if (yumi_i) begin
                full_m = 1'b0;
                cd.delete();
                cs.delete();
                if (acc) model_apply(data_i, sel_i);
            end
        end else if (acc) begin
            model_apply(data_i, sel_i);
            if (complete()) full_m = 1'b1;
        end
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input logic [W-1:0] s, input bit y);
        @(negedge clk);
        v_i    = v;
        data_i = d;
        sel_i  = s;
        yumi_i = y;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        v_i     = 1'b0;
        yumi_i  = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        drive(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0); model_step();
        drive(1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0); model_step();
        @(negedge clk);
        v_i     = 1'b1;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o: got %b want 0", v_o); end
            checks++;
            if (o0_o !== '0) begin errors++; $display("FAIL reset_o0: got %h want 0", o0_o); end
            checks++;
            if (o1_o !== '0) begin errors++; $display("FAIL reset_o1: got %h want 0", o1_o); end
            checks++;
            if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b want 0", ready_o); end
            @(negedge clk);
            #1;
        end
        reset_n = 1'b1;
        v_i     = 1'b0;
        model_reset();
        #1;
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_release: got %b want 1", ready_o); end
    endtask

    task automatic test_basic_pair();
        do_reset();
        drive(1'b1, 32'h0000_FFFF, 32'h0000_0000, 1'b0); model_step();
        drive(1'b1, 32'hFFFF_0000, 32'hFFFF_FFFF, 1'b0); model_step();
        drive(1'b0, '0, '0, 1'b0);
        checks++;
        if (v_o !== 1'b1) begin errors++; $display("FAIL pair_v_o: got %b want 1", v_o); end
        checks++;
        if (o0_o !== 32'hFFFF_0000) begin errors++; $display("FAIL pair_o0: got %h want ffff0000", o0_o); end
        checks++;
        if (o1_o !== 32'h0000_FFFF) begin errors++; $display("FAIL pair_o1: got %h want 0000ffff", o1_o); end
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL pair_ready_full: got %b want 0", ready_o); end
        model_step();
        drive(1'b0, '0, '0, 1'b1); model_step();
        drive(1'b0, '0, '0, 1'b0);
        checks++;
        if (v_o !== 1'b0) begin errors++; $display("FAIL pair_after_yumi: got %b want 0", v_o); end
        model_step();
    endtask

    task automatic test_partial_overwrite();
        logic [15:0] lo;
        do_reset();
        drive(1'b1, 32'h0000_0000, 32'h0000_FFFF, 1'b0); model_step();
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0); model_step();
        drive(1'b0, '0, '0, 1'b0);
        lo = o1_o[15:0];
        checks++;
        if (v_o !== 1'b0) begin errors++; $display("FAIL partial_v_o: got %b want 0", v_o); end
        checks++;
        if (lo !== 16'h0000) begin errors++; $display("FAIL partial_overwrite_o1lo: got %h want 0000", lo); end
        model_step();
        drive(1'b1, $urandom, 32'hFFFF_0000, 1'b0); model_step();
        drive(1'b1, $urandom, 32'h0000_FFFF, 1'b0); model_step();
        drive(1'b0, '0, '0, 1'b0);
        checks++;
        if (v_o !== 1'b1) begin errors++; $display("FAIL partial_complete_v_o: got %b want 1", v_o); end
        checks++;
        if (o0_o !== o0_m || o1_o !== o1_m) begin
            errors++;
            $display("FAIL partial_words: got %h/%h want %h/%h", o0_o, o1_o, o0_m, o1_m);
        end
        model_step();
        drive(1'b0, '0, '0, 1'b1); model_step();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] s0, s1;
        do_reset();
        drive(1'b1, $urandom, 32'h0000_0000, 1'b0); model_step();
        drive(1'b1, $urandom, 32'hFFFF_FFFF, 1'b0); model_step();
        s0 = o0_m;
        s1 = o1_m;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, $urandom, $urandom, 1'b0);
            checks++;
            if (v_o !== 1'b1 || ready_o !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_ctrl: got v_o=%b ready=%b want 1/0", v_o, ready_o);
            end
            checks++;
            if (o0_o !== s0 || o1_o !== s1) begin
                errors++;
                $display("FAIL backpressure_hold: got %h/%h want %h/%h", o0_o, o1_o, s0, s1);
            end
            model_step();
        end
        drive(1'b0, '0, '0, 1'b1); model_step();
        drive(1'b0, '0, '0, 1'b0);
        checks++;
        if (v_o !== 1'b0) begin errors++; $display("FAIL backpressure_release: got %b want 0", v_o); end
        model_step();
    endtask

    task automatic test_flowthru();
        do_reset();
        drive(1'b1, $urandom, 32'h0000_0000, 1'b0); model_step();
        drive(1'b1, $urandom, 32'hFFFF_FFFF, 1'b0); model_step();
        drive(1'b1, $urandom, 32'h0F0F_0F0F, 1'b1);
        checks++;
        if (ready_o !== FLOW) begin errors++; $display("FAIL flow_ready_in_yumi: got %b want %b", ready_o, FLOW); end
        model_step();
        drive(1'b1, $urandom, 32'hF0F0_F0F0, 1'b0);
        checks++;
        if (v_o !== 1'b0) begin errors++; $display("FAIL flow_v_o_after_yumi: got %b want 0", v_o); end
        model_step();
        drive(1'b0, '0, '0, 1'b0);
        checks++;
        if (v_o !== FLOW) begin errors++; $display("FAIL flow_complete: got %b want %b", v_o, FLOW); end
        checks++;
        if (o0_o !== o0_m || o1_o !== o1_m) begin
            errors++;
            $display("FAIL flow_words: got %h/%h want %h/%h", o0_o, o1_o, o0_m, o1_m);
        end
        model_step();
    endtask

    task automatic test_random();
        bit           v, y;
        logic [W-1:0] d, s, rt;
        do_reset();
        for (int k = 0; k < 10000; k++) begin
            v = ($urandom_range(3) != 0);
            y = full_m && ($urandom_range(1) == 1);
            d = $urandom;
            s = $urandom;
            drive(v, d, s, y);
            checks++;
            if (v_o !== full_m || ready_o !== model_ready(y)) begin
                errors++;
                $display("FAIL random_ctrl @%0d: got v_o=%b ready=%b want %b/%b", k, v_o, ready_o, full_m, model_ready(y));
            end
            checks++;
            if (o0_o !== o0_m || o1_o !== o1_m) begin
                errors++;
                $display("FAIL random_words @%0d: got %h/%h want %h/%h", k, o0_o, o1_o, o0_m, o1_m);
            end
            if (full_m && cd.size() > 0) begin
                rt = ~((cs[$] & o1_o) | (~cs[$] & o0_o));
                checks++;
                if (rt !== cd[$]) begin
                    errors++;
                    $display("FAIL random_roundtrip @%0d: got %h want %h", k, rt, cd[$]);
                end
            end
            model_step();
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_basic_pair();
        test_partial_overwrite();
        test_backpressure();
        test_flowthru();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
